dmem_scheduler: RTL and testbench
=================================

# dmem_scheduler

Sequences the single data-memory port between the store buffer head and the load queue head. Stores are issued only when non-speculative, meaning their ROB entry is at the ROB head. Loads fill the remaining port slots. The block handshakes each access with memory, pops the source queue on grant, reports completions to the ROB/writeback stage, discards in-flight loads on a pipeline flush, and flags hung memory accesses.

## Interface
Parameters:
- TIMEOUT, 64, cycles of unacknowledged mem_req before err is set (≥1)
- ROB_AW, $clog2(`ROB_LENGTH), ROB address width
- REG_AW, $clog2(`NUM_D_REG), physical register index width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  branch-mispredict / checkpoint-restore flush
- rob_head  in  ROB_AW  current oldest ROB entry
- sb_valid  in  1  store buffer head is valid and has operands ready
- sb_rob_addr  in  ROB_AW  ROB entry of the store buffer head
- sb_ra_addr, sb_rt_addr  in  REG_AW each  address / data register indices of the store
- sb_pop  out  1  store buffer head accepted this cycle
- ld_valid  in  1  load queue head is valid and ready
- ld_rob_addr  in  ROB_AW  ROB entry of the load
- ld_ra_addr, ld_rt_addr  in  REG_AW each  address / destination register indices of the load
- ld_pop  out  1  load queue head accepted this cycle
- mem_req  out  1  memory access outstanding
- mem_we  out  1  1 = store, 0 = load; valid while mem_req
- mem_ra_addr, mem_rt_addr  out  REG_AW each  latched operand indices; valid while mem_req
- mem_ack  in  1  memory completes the outstanding access this cycle
- st_done  out  1  pulse: store completed
- ld_done  out  1  pulse: load completed; destination written
- done_rob_addr  out  ROB_AW  ROB entry for st_done / ld_done
- done_rt_addr  out  REG_AW  load destination register, valid with ld_done
- busy  out  1  state ≠ IDLE
- err  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, STORE, LOAD, DRAIN.
- Eligibility, evaluated in IDLE only:
  - st_ok = sb_valid & (sb_rob_addr == rob_head) & ~flush
  - ld_ok = ld_valid & ~flush
- Grants in IDLE:
  - st_ok → sb_pop = 1 combinationally. Latch rob/ra/rt fields. Next state STORE.
  - st_ok = 0 and ld_ok → ld_pop = 1. Latch fields. Next state LOAD.
  - When both are eligible, the store wins. The store at the ROB head is the oldest instruction.
  - sb_pop and ld_pop are never both high, and both are 0 outside IDLE.
- STORE: mem_req = 1, mem_we = 1.
  - On mem_ack: st_done = 1 next cycle with the latched rob address. Go to IDLE.
  - flush is ignored in STORE because the store is already committed.
- LOAD: mem_req = 1, mem_we = 0.
  - mem_ack & ~flush → ld_done next cycle. Go to IDLE.
  - flush & mem_ack in the same cycle → IDLE, no ld_done.
  - flush & ~mem_ack → DRAIN.
- DRAIN: mem_req stays 1, since the access cannot be cancelled. On mem_ack → IDLE with no done pulse. Further flushes have no effect.
- Watchdog:
  - Counter width is $clog2(TIMEOUT+1). It is cleared on grant and on mem_ack, and increments each cycle with mem_req & ~mem_ack. It saturates.
  - err sets when the counter reaches TIMEOUT and holds until rst.
  - The FSM keeps waiting after err is set.
- The ROB address compare is an equality test only. No modular age arithmetic.

## Timing
- Reset values: state IDLE. mem_req, mem_we, st_done, ld_done, busy, err, and the counter are 0. Latched fields and done_rob_addr / done_rt_addr are 0.
- Asserting rst mid-access drops mem_req immediately (asynchronous reset). No done pulse is produced.
- Grant cycle: the pop is combinational in IDLE. mem_req is registered and goes high the following cycle.
- mem_req stays high through the cycle in which mem_ack is sampled and is low the next cycle, which is IDLE.
- st_done / ld_done are registered single-cycle pulses, one cycle after the mem_ack cycle.
- The next grant can occur in that same IDLE cycle, concurrent with the done pulse.
- Minimum period is 2 cycles per access: IDLE grant, then a request cycle with immediate ack.
- mem_ack while in IDLE is ignored.

## Test plan
- Reset, then sb_valid = 1 with sb_rob_addr = 3 = rob_head, mem_ack on the first request cycle → sb_pop at cycle 0, mem_req/mem_we high at cycle 1, st_done with done_rob_addr = 3 at cycle 2.
- Store and load eligible together, rob_head = 5, sb_rob_addr = 5, ld_rob_addr = 6 → store granted first. Load granted in the IDLE cycle after the store ack; ld_pop never coincides with sb_pop.
- sb_valid = 1 with sb_rob_addr = 7 ≠ rob_head = 4, plus ld_valid = 1 → load issued, no sb_pop. Store issues once rob_head = 7.
- Load in flight, flush pulsed with no ack, mem_ack 3 cycles later → DRAIN with mem_req held high. Return to IDLE with no ld_done. flush during IDLE produces no pop.
- TIMEOUT = 4, mem_ack withheld → err high 4 cycles after mem_req rises. err stays high after a late ack, until rst.
- Assert rst during a LOAD → mem_req, busy, and ld_done are 0 immediately. Normal grants resume after rst drops.

Source files
------------

// File: rtl/dmem_scheduler.sv
// dmem_scheduler: arbitrates the single data-memory port between the
// committed store-buffer head and the load-queue head.
`ifndef ROB_LENGTH
`define ROB_LENGTH 32
`endif
`ifndef NUM_D_REG
`define NUM_D_REG 64
`endif

module dmem_scheduler #(
  parameter int TIMEOUT = 64,
  parameter int ROB_AW  = $clog2(`ROB_LENGTH),
  parameter int REG_AW  = $clog2(`NUM_D_REG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ROB_AW-1:0] rob_head,
  input  logic              sb_valid,
  input  logic [ROB_AW-1:0] sb_rob_addr,
  input  logic [REG_AW-1:0] sb_ra_addr,
  input  logic [REG_AW-1:0] sb_rt_addr,
  output logic              sb_pop,
  input  logic              ld_valid,
  input  logic [ROB_AW-1:0] ld_rob_addr,
  input  logic [REG_AW-1:0] ld_ra_addr,
  input  logic [REG_AW-1:0] ld_rt_addr,
  output logic              ld_pop,
  output logic              mem_req,
  output logic              mem_we,
  output logic [REG_AW-1:0] mem_ra_addr,
  output logic [REG_AW-1:0] mem_rt_addr,
  input  logic              mem_ack,
  output logic              st_done,
  output logic              ld_done,
  output logic [ROB_AW-1:0] done_rob_addr,
  output logic [REG_AW-1:0] done_rt_addr,
  output logic              busy,
  output logic              err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE, STORE, LOAD, DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [ROB_AW-1:0] lat_rob;
  logic [REG_AW-1:0] lat_ra;
  logic [REG_AW-1:0] lat_rt;
  logic [CW-1:0]     cnt;
  logic              st_ok;
  logic              ld_ok;

  assign st_ok = sb_valid & (sb_rob_addr == rob_head) & ~flush;
  assign ld_ok = ld_valid & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (st_ok)      state_nxt = STORE;
        else if (ld_ok) state_nxt = LOAD;
      end
      STORE: if (mem_ack) state_nxt = IDLE;
      LOAD: begin
        if (mem_ack)    state_nxt = IDLE;
        else if (flush) state_nxt = DRAIN;
      end
      DRAIN: if (mem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sb_pop  = 1'b0;
    ld_pop  = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    unique case (state)
      IDLE: begin
        sb_pop = st_ok;
        ld_pop = ~st_ok & ld_ok;
      end
      STORE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      LOAD:    mem_req = 1'b1;
      DRAIN:   mem_req = 1'b1;
      default: mem_req = 1'b0;
    endcase
  end

  assign busy        = mem_req;
  assign mem_ra_addr = lat_ra;
  assign mem_rt_addr = lat_rt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_rob <= '0;
      lat_ra  <= '0;
      lat_rt  <= '0;
    end else if (sb_pop) begin
      lat_rob <= sb_rob_addr;
      lat_ra  <= sb_ra_addr;
      lat_rt  <= sb_rt_addr;
    end else if (ld_pop) begin
      lat_rob <= ld_rob_addr;
      lat_ra  <= ld_ra_addr;
      lat_rt  <= ld_rt_addr;
    end
  end

  // A flushed load still owns the port but must not write back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_done       <= 1'b0;
      ld_done       <= 1'b0;
      done_rob_addr <= '0;
      done_rt_addr  <= '0;
    end else begin
      st_done <= (state == STORE) & mem_ack;
      ld_done <= (state == LOAD) & mem_ack & ~flush;
      if (mem_ack && (state == STORE || state == LOAD)) begin
        done_rob_addr <= lat_rob;
        done_rt_addr  <= lat_rt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (sb_pop || ld_pop || mem_ack)
        cnt <= '0;
      else if (mem_req && cnt != TMAX)
        cnt <= cnt + CW'(1);
      if (mem_req && !mem_ack && cnt >= TLIM)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_scheduler.sv
// tb_dmem_scheduler: directed scenario tests for dmem_scheduler
// with hand-computed expected values.
module tb_dmem_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [3:0] rob_head;
  logic       sb_valid;
  logic [3:0] sb_rob_addr;
  logic [5:0] sb_ra_addr, sb_rt_addr;
  logic       sb_pop;
  logic       ld_valid;
  logic [3:0] ld_rob_addr;
  logic [5:0] ld_ra_addr, ld_rt_addr;
  logic       ld_pop;
  logic       mem_req, mem_we;
  logic [5:0] mem_ra_addr, mem_rt_addr;
  logic       mem_ack;
  logic       st_done, ld_done;
  logic [3:0] done_rob_addr;
  logic [5:0] done_rt_addr;
  logic       busy, err;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  dmem_scheduler #(.TIMEOUT(4), .ROB_AW(4), .REG_AW(6)) dut (
    .clk(clk), .rst(rst), .flush(flush), .rob_head(rob_head),
    .sb_valid(sb_valid), .sb_rob_addr(sb_rob_addr),
    .sb_ra_addr(sb_ra_addr), .sb_rt_addr(sb_rt_addr), .sb_pop(sb_pop),
    .ld_valid(ld_valid), .ld_rob_addr(ld_rob_addr),
    .ld_ra_addr(ld_ra_addr), .ld_rt_addr(ld_rt_addr), .ld_pop(ld_pop),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_ra_addr(mem_ra_addr), .mem_rt_addr(mem_rt_addr),
    .mem_ack(mem_ack), .st_done(st_done), .ld_done(ld_done),
    .done_rob_addr(done_rob_addr), .done_rt_addr(done_rt_addr),
    .busy(busy), .err(err)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    flush = 0; rob_head = 0; mem_ack = 0;
    sb_valid = 0; sb_rob_addr = 0; sb_ra_addr = 0; sb_rt_addr = 0;
    ld_valid = 0; ld_rob_addr = 0; ld_ra_addr = 0; ld_rt_addr = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    flush = 0; rob_head = 0; mem_ack = 0;
    sb_valid = 1; sb_rob_addr = 0; sb_ra_addr = 0; sb_rt_addr = 0;
    ld_valid = 1; ld_rob_addr = 0; ld_ra_addr = 0; ld_rt_addr = 0;
    step();
    checks++; if (mem_req !== 1'b0) $display("FAIL rst_req got %b want 0", mem_req); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL rst_err got %b want 0", err); else passes++;
    checks++; if ({st_done, ld_done} !== 2'b00) $display("FAIL rst_done got %b want 00", {st_done, ld_done}); else passes++;
    checks++; if (done_rob_addr !== 4'd0) $display("FAIL rst_drob got %0d want 0", done_rob_addr); else passes++;
    checks++; if (mem_rt_addr !== 6'd0) $display("FAIL rst_mrt got %0d want 0", mem_rt_addr); else passes++;
  endtask

  task automatic test_store;
    do_reset();
    rob_head = 3; sb_valid = 1; sb_rob_addr = 3; sb_ra_addr = 5; sb_rt_addr = 9;
    #1;
    checks++; if ({sb_pop, ld_pop} !== 2'b10) $display("FAIL st_pop got %b want 10", {sb_pop, ld_pop}); else passes++;
    step();
    sb_valid = 0; mem_ack = 1;
    #1;
    checks++; if ({mem_req, mem_we} !== 2'b11) $display("FAIL st_req got %b want 11", {mem_req, mem_we}); else passes++;
    checks++; if ({mem_ra_addr, mem_rt_addr} !== {6'd5, 6'd9}) $display("FAIL st_ops got %0d/%0d want 5/9", mem_ra_addr, mem_rt_addr); else passes++;
    step();
    mem_ack = 0;
    checks++; if (st_done !== 1'b1) $display("FAIL st_done got %b want 1", st_done); else passes++;
    checks++; if (done_rob_addr !== 4'd3) $display("FAIL st_drob got %0d want 3", done_rob_addr); else passes++;
    checks++; if (mem_req !== 1'b0) $display("FAIL st_reqlo got %b want 0", mem_req); else passes++;
    step();
    checks++; if (st_done !== 1'b0) $display("FAIL st_pulse got %b want 0", st_done); else passes++;
  endtask

  task automatic test_priority;
    do_reset();
    rob_head = 5; sb_valid = 1; sb_rob_addr = 5;
    ld_valid = 1; ld_rob_addr = 6; ld_rt_addr = 12;
    #1;
    checks++; if ({sb_pop, ld_pop} !== 2'b10) $display("FAIL pri_g0 got %b want 10", {sb_pop, ld_pop}); else passes++;
    step();
    sb_valid = 0; mem_ack = 1;
    #1;
    checks++; if ({ld_pop, mem_we} !== 2'b01) $display("FAIL pri_st got %b want 01", {ld_pop, mem_we}); else passes++;
    step();
    mem_ack = 0;
    #1;
    checks++; if ({st_done, sb_pop, ld_pop} !== 3'b101) $display("FAIL pri_g1 got %b want 101", {st_done, sb_pop, ld_pop}); else passes++;
    step();
    ld_valid = 0; mem_ack = 1;
    #1;
    checks++; if ({mem_req, mem_we} !== 2'b10) $display("FAIL pri_ld got %b want 10", {mem_req, mem_we}); else passes++;
    step();
    mem_ack = 0;
    checks++; if (ld_done !== 1'b1) $display("FAIL pri_ldone got %b want 1", ld_done); else passes++;
    checks++; if ({done_rob_addr, done_rt_addr} !== {4'd6, 6'd12}) $display("FAIL pri_dst got %0d/%0d want 6/12", done_rob_addr, done_rt_addr); else passes++;
  endtask

  task automatic test_not_head;
    do_reset();
    rob_head = 4; sb_valid = 1; sb_rob_addr = 7;
    ld_valid = 1; ld_rob_addr = 2;
    #1;
    checks++; if ({sb_pop, ld_pop} !== 2'b01) $display("FAIL nh_g0 got %b want 01", {sb_pop, ld_pop}); else passes++;
    step();
    ld_valid = 0; mem_ack = 1;
    #1;
    checks++; if ({sb_pop, mem_we} !== 2'b00) $display("FAIL nh_ld got %b want 00", {sb_pop, mem_we}); else passes++;
    step();
    mem_ack = 0;
    #1;
    checks++; if ({ld_done, sb_pop} !== 2'b10) $display("FAIL nh_wait got %b want 10", {ld_done, sb_pop}); else passes++;
    rob_head = 7;
    #1;
    checks++; if (sb_pop !== 1'b1) $display("FAIL nh_g1 got %b want 1", sb_pop); else passes++;
    step();
    sb_valid = 0; mem_ack = 1;
    step();
    mem_ack = 0;
    checks++; if ({st_done, done_rob_addr} !== {1'b1, 4'd7}) $display("FAIL nh_sdone got %b/%0d want 1/7", st_done, done_rob_addr); else passes++;
  endtask

  task automatic test_flush_drain;
    do_reset();
    ld_valid = 1; ld_rob_addr = 1; ld_rt_addr = 3;
    step();
    ld_valid = 0; flush = 1;
    step();
    flush = 0;
    #1;
    checks++; if ({mem_req, busy} !== 2'b11) $display("FAIL fd_drain got %b want 11", {mem_req, busy}); else passes++;
    step();
    flush = 1;
    step();
    flush = 0; mem_ack = 1;
    #1;
    checks++; if (mem_req !== 1'b1) $display("FAIL fd_hold got %b want 1", mem_req); else passes++;
    step();
    mem_ack = 0;
    checks++; if ({mem_req, ld_done, st_done} !== 3'b000) $display("FAIL fd_end got %b want 000", {mem_req, ld_done, st_done}); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL fd_err got %b want 0", err); else passes++;
    flush = 1; ld_valid = 1; sb_valid = 1; sb_rob_addr = rob_head;
    #1;
    checks++; if ({sb_pop, ld_pop} !== 2'b00) $display("FAIL fd_idle got %b want 00", {sb_pop, ld_pop}); else passes++;
    flush = 0; ld_valid = 0; sb_valid = 0;
  endtask

  task automatic test_timeout;
    do_reset();
    ld_valid = 1; ld_rob_addr = 2;
    step();
    ld_valid = 0;
    repeat (3) step();
    checks++; if (err !== 1'b0) $display("FAIL to_early got %b want 0", err); else passes++;
    step();
    checks++; if (err !== 1'b1) $display("FAIL to_set got %b want 1", err); else passes++;
    mem_ack = 1;
    step();
    mem_ack = 0;
    step();
    checks++; if ({err, mem_req} !== 2'b10) $display("FAIL to_hold got %b want 10", {err, mem_req}); else passes++;
    rst = 1;
    #1;
    checks++; if (err !== 1'b0) $display("FAIL to_clr got %b want 0", err); else passes++;
    rst = 0;
  endtask

  task automatic test_rst_mid;
    do_reset();
    ld_valid = 1; ld_rob_addr = 4;
    step();
    ld_valid = 0;
    #1;
    checks++; if (mem_req !== 1'b1) $display("FAIL rm_req got %b want 1", mem_req); else passes++;
    rst = 1;
    #1;
    checks++; if ({mem_req, busy, ld_done} !== 3'b000) $display("FAIL rm_async got %b want 000", {mem_req, busy, ld_done}); else passes++;
    step();
    rst = 0;
    ld_valid = 1; ld_rob_addr = 8;
    #1;
    checks++; if (ld_pop !== 1'b1) $display("FAIL rm_resume got %b want 1", ld_pop); else passes++;
    step();
    ld_valid = 0; mem_ack = 1;
    step();
    mem_ack = 0;
    checks++; if ({ld_done, done_rob_addr} !== {1'b1, 4'd8}) $display("FAIL rm_done got %b/%0d want 1/8", ld_done, done_rob_addr); else passes++;
  endtask

  initial begin
    test_reset();
    test_store();
    test_priority();
    test_not_head();
    test_flush_drain();
    test_timeout();
    test_rst_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
